// File: rtl/simd_compute_issue.sv
// -----------------------------------------------------------------------------
// simd_compute_issue
//
// Instruction-side driver for the SIMD compute unit. It accepts one vector
// instruction at a time, walks the strided source descriptors to issue one
// operand-buffer read per element, and drives the compute unit's opcode,
// function and accumulator-reset controls. A valid shift register that spans
// the read latency plus the compute latency marks the cycle in which each
// result leaves the compute unit's output register. The result-buffer write
// strobe and the destination address are produced in that cycle.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   inst_valid / inst_ready        instruction handshake (ready only in IDLE)
//   inst_opcode, inst_fn           compute-unit opcode / function
//   inst_num_iter                  element count N (0 is legal)
//   inst_acc                       1 = reduce all N elements into one result
//   inst_src{0,1}_base/_stride     strided source descriptors
//   inst_dst_base/_stride          strided destination descriptor
//   stall                          suspend issue (ignored for acc instructions)
//   src_rd_en, src{0,1}_rd_addr    operand-buffer read strobe and addresses
//   cu_opcode, cu_fn, cu_acc_reset compute-unit controls
//   dst_wr_en, dst_wr_addr         result-buffer write strobe and address
//   busy, done                     instruction in flight / completion pulse
//
// Every output is a register. The always_comb block computes the value that
// each output takes in the next cycle.
// -----------------------------------------------------------------------------
module simd_compute_issue #(
    parameter int OPCODE_BITS   = 4,
    parameter int FUNCTION_BITS = 4,
    parameter int ADDR_WIDTH    = 16,
    parameter int COUNT_WIDTH   = 16,
    parameter int RD_LATENCY    = 1,
    parameter int CU_LATENCY    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inst_valid,
    output logic                     inst_ready,
    input  logic [OPCODE_BITS-1:0]   inst_opcode,
    input  logic [FUNCTION_BITS-1:0] inst_fn,
    input  logic [COUNT_WIDTH-1:0]   inst_num_iter,
    input  logic                     inst_acc,
    input  logic [ADDR_WIDTH-1:0]    inst_src0_base,
    input  logic [ADDR_WIDTH-1:0]    inst_src0_stride,
    input  logic [ADDR_WIDTH-1:0]    inst_src1_base,
    input  logic [ADDR_WIDTH-1:0]    inst_src1_stride,
    input  logic [ADDR_WIDTH-1:0]    inst_dst_base,
    input  logic [ADDR_WIDTH-1:0]    inst_dst_stride,
    input  logic                     stall,
    output logic                     src_rd_en,
    output logic [ADDR_WIDTH-1:0]    src0_rd_addr,
    output logic [ADDR_WIDTH-1:0]    src1_rd_addr,
    output logic [OPCODE_BITS-1:0]   cu_opcode,
    output logic [FUNCTION_BITS-1:0] cu_fn,
    output logic                     cu_acc_reset,
    output logic                     dst_wr_en,
    output logic [ADDR_WIDTH-1:0]    dst_wr_addr,
    output logic                     busy,
    output logic                     done
);

    // An element issued in cycle c has its result written in cycle c + L.
    localparam int L = RD_LATENCY + CU_LATENCY;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Instruction fields that are held for the duration of the instruction.
    logic [OPCODE_BITS-1:0]   opcode_q;
    logic [FUNCTION_BITS-1:0] fn_q;
    logic                     acc_q;
    logic [ADDR_WIDTH-1:0]    src0_stride_q, src1_stride_q;
    logic [ADDR_WIDTH-1:0]    dst_base_q, dst_stride_q;

    // Running address generators. Each one holds the address that the next
    // element uses.
    logic [ADDR_WIDTH-1:0] src0_ptr, src1_ptr, dst_ptr;
    logic [ADDR_WIDTH-1:0] src0_ptr_nxt, src1_ptr_nxt, dst_ptr_nxt;

    // Elements not yet issued, plus a flag for "element 0 not yet issued".
    logic [COUNT_WIDTH-1:0] left_q, left_nxt;
    logic                   first_q, first_nxt;

    // Element pipeline. Index k holds the element issued k cycles ago.
    logic [L-1:0] vld_p, first_p, last_p;
    logic [L-1:0] vld_p_nxt, first_p_nxt, last_p_nxt;

    // Effective values for this cycle. On the acceptance cycle they come
    // straight from the instruction port.
    logic                   accept;
    logic                   eff_acc;
    logic [COUNT_WIDTH-1:0] left_cur;
    logic                   first_cur;
    logic [ADDR_WIDTH-1:0]  cur0, cur1, str0, str1;
    logic                   issue;

    // Next-cycle output values.
    logic                     inst_ready_nxt, busy_nxt, done_nxt;
    logic                     src_rd_en_nxt, dst_wr_en_nxt, cu_acc_reset_nxt;
    logic [ADDR_WIDTH-1:0]    src0_rd_addr_nxt, src1_rd_addr_nxt, dst_wr_addr_nxt;
    logic [OPCODE_BITS-1:0]   cu_opcode_nxt;
    logic [FUNCTION_BITS-1:0] cu_fn_nxt;

    always_comb begin
        accept    = inst_ready && inst_valid;
        eff_acc   = accept ? inst_acc         : acc_q;
        left_cur  = accept ? inst_num_iter    : left_q;
        first_cur = accept ? 1'b1             : first_q;
        cur0      = accept ? inst_src0_base   : src0_ptr;
        cur1      = accept ? inst_src1_base   : src1_ptr;
        str0      = accept ? inst_src0_stride : src0_stride_q;
        str1      = accept ? inst_src1_stride : src1_stride_q;

        // The compute unit has no enable, so an accumulating reduction must
        // not be broken up. Stall only gates non-acc instructions. Stall is
        // sampled one cycle ahead of the read strobe that it suppresses.
        issue = (accept || (state == ISSUE)) && (left_cur != '0) &&
                !(stall && !eff_acc);

        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    // An empty instruction goes through one DRAIN cycle. That
                    // cycle carries busy and the done pulse.
                    state_nxt = (inst_num_iter == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (left_q == '0) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        left_nxt     = left_cur - COUNT_WIDTH'(issue);
        first_nxt    = first_cur && !issue;
        src0_ptr_nxt = issue ? cur0 + str0 : cur0;
        src1_ptr_nxt = issue ? cur1 + str1 : cur1;

        vld_p_nxt      = '0;
        first_p_nxt    = '0;
        last_p_nxt     = '0;
        vld_p_nxt[0]   = issue;
        first_p_nxt[0] = issue && first_cur;
        last_p_nxt[0]  = issue && (left_cur == COUNT_WIDTH'(1));
        for (int k = 1; k < L; k++) begin
            vld_p_nxt[k]   = vld_p[k-1];
            first_p_nxt[k] = first_p[k-1];
            last_p_nxt[k]  = last_p[k-1];
        end

        src_rd_en_nxt    = issue;
        src0_rd_addr_nxt = issue ? cur0 : src0_rd_addr;
        src1_rd_addr_nxt = issue ? cur1 : src1_rd_addr;

        // The oldest pipeline slot holds the element whose result appears on
        // the compute-unit output in the next cycle. A reduction writes only
        // its last element, and always to dst_base.
        dst_wr_en_nxt   = vld_p[L-1] && (!acc_q || last_p[L-1]);
        dst_wr_addr_nxt = dst_wr_en_nxt ? (acc_q ? dst_base_q : dst_ptr) : dst_wr_addr;
        dst_ptr_nxt     = accept ? inst_dst_base :
                          (dst_wr_en_nxt && !acc_q) ? dst_ptr + dst_stride_q : dst_ptr;

        done_nxt       = (accept && (inst_num_iter == '0)) || (vld_p[L-1] && last_p[L-1]);
        busy_nxt       = (state_nxt != IDLE);
        inst_ready_nxt = (state_nxt == IDLE);

        cu_opcode_nxt = busy_nxt ? (accept ? inst_opcode : opcode_q) : '0;
        cu_fn_nxt     = busy_nxt ? (accept ? inst_fn     : fn_q)     : '0;

        // Element 0 reaches the compute-unit inputs RD_LATENCY cycles after it
        // is issued. This is the only cycle in which a reduction clears its
        // feedback. Element-wise instructions keep the feedback cleared for
        // the whole instruction.
        cu_acc_reset_nxt = busy_nxt &&
                           (!eff_acc || (vld_p[RD_LATENCY-1] && first_p[RD_LATENCY-1]));
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            inst_ready   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            src_rd_en    <= 1'b0;
            dst_wr_en    <= 1'b0;
            cu_acc_reset <= 1'b0;
            cu_opcode    <= '0;
            cu_fn        <= '0;
            src0_rd_addr <= '0;
            src1_rd_addr <= '0;
            dst_wr_addr  <= '0;
            vld_p        <= '0;
        end else begin
            state        <= state_nxt;
            inst_ready   <= inst_ready_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            src_rd_en    <= src_rd_en_nxt;
            dst_wr_en    <= dst_wr_en_nxt;
            cu_acc_reset <= cu_acc_reset_nxt;
            cu_opcode    <= cu_opcode_nxt;
            cu_fn        <= cu_fn_nxt;
            src0_rd_addr <= src0_rd_addr_nxt;
            src1_rd_addr <= src1_rd_addr_nxt;
            dst_wr_addr  <= dst_wr_addr_nxt;
            vld_p        <= vld_p_nxt;
        end
    end

    // Instruction latch and datapath registers. These registers are only
    // meaningful while the pipeline valid bits say so, so they are not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            opcode_q      <= inst_opcode;
            fn_q          <= inst_fn;
            acc_q         <= inst_acc;
            src0_stride_q <= inst_src0_stride;
            src1_stride_q <= inst_src1_stride;
            dst_base_q    <= inst_dst_base;
            dst_stride_q  <= inst_dst_stride;
        end
        src0_ptr <= src0_ptr_nxt;
        src1_ptr <= src1_ptr_nxt;
        dst_ptr  <= dst_ptr_nxt;
        left_q   <= left_nxt;
        first_q  <= first_nxt;
        first_p  <= first_p_nxt;
        last_p   <= last_p_nxt;
    end

endmodule

// File: tb/tb_simd_compute_issue.sv
// -----------------------------------------------------------------------------
// tb_simd_compute_issue
//
// Bench for simd_compute_issue with RD_LATENCY=1 and CU_LATENCY=1, so L=2.
// A table of instructions is built, each with a hand-derived completion cycle.
// For every instruction, the expected reads and writes are pushed to
// scoreboard queues when the instruction is driven. Each one is popped and
// compared when the DUT strobes it. Cycle c is the cycle whose outputs are
// sampled 1 time unit after the c-th rising edge that follows acceptance.
// stall_mask bit c asks for the issue in cycle c to be suppressed, so stall
// is driven during cycle c-1.
// -----------------------------------------------------------------------------
module tb_simd_compute_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic        inst_ready;
    logic [3:0]  inst_opcode;
    logic [3:0]  inst_fn;
    logic [15:0] inst_num_iter;
    logic        inst_acc;
    logic [15:0] inst_src0_base, inst_src0_stride;
    logic [15:0] inst_src1_base, inst_src1_stride;
    logic [15:0] inst_dst_base, inst_dst_stride;
    logic        stall;
    logic        src_rd_en;
    logic [15:0] src0_rd_addr, src1_rd_addr;
    logic [3:0]  cu_opcode, cu_fn;
    logic        cu_acc_reset;
    logic        dst_wr_en;
    logic [15:0] dst_wr_addr;
    logic        busy, done;

    simd_compute_issue #(
        .OPCODE_BITS(4), .FUNCTION_BITS(4), .ADDR_WIDTH(16), .COUNT_WIDTH(16),
        .RD_LATENCY(1), .CU_LATENCY(1)
    ) dut (
        .clk(clk), .reset(reset),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_opcode(inst_opcode), .inst_fn(inst_fn),
        .inst_num_iter(inst_num_iter), .inst_acc(inst_acc),
        .inst_src0_base(inst_src0_base), .inst_src0_stride(inst_src0_stride),
        .inst_src1_base(inst_src1_base), .inst_src1_stride(inst_src1_stride),
        .inst_dst_base(inst_dst_base), .inst_dst_stride(inst_dst_stride),
        .stall(stall),
        .src_rd_en(src_rd_en), .src0_rd_addr(src0_rd_addr), .src1_rd_addr(src1_rd_addr),
        .cu_opcode(cu_opcode), .cu_fn(cu_fn), .cu_acc_reset(cu_acc_reset),
        .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic        acc;
        logic [3:0]  op;
        logic [3:0]  fn;
        logic [15:0] s0b, s0s, s1b, s1s, db, ds;
        logic [31:0] stall_mask;
        int          exp_done;
    } vec_t;

    typedef struct { int cyc; logic [15:0] a0; logic [15:0] a1; } rd_t;
    typedef struct { int cyc; logic [15:0] a; } wr_t;

    rd_t  rd_q[$];
    wr_t  wr_q[$];
    vec_t vecs[6];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        inst_valid = 1'b0; inst_opcode = '0; inst_fn = '0; inst_num_iter = '0;
        inst_acc = 1'b0; inst_src0_base = '0; inst_src0_stride = '0;
        inst_src1_base = '0; inst_src1_stride = '0; inst_dst_base = '0;
        inst_dst_stride = '0; stall = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int c;
        int cyc;
        int t;
        logic [15:0] a0, a1, d;
        logic exp_ar;
        rd_t r;
        wr_t w;

        t = 0;
        while (inst_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check({tag, "_ready_in"}, inst_ready, 1);

        // Expected traffic, derived from base + i*stride and the stall mask
        rd_q.delete();
        wr_q.delete();
        c = 1; a0 = v.s0b; a1 = v.s1b; d = v.db;
        for (int i = 0; i < v.n; i++) begin
            while (!v.acc && v.stall_mask[c]) c++;
            r.cyc = c; r.a0 = a0; r.a1 = a1;
            rd_q.push_back(r);
            if (!v.acc || i == v.n - 1) begin
                w.cyc = c + 2;
                w.a   = v.acc ? v.db : d;
                wr_q.push_back(w);
            end
            a0 += v.s0s; a1 += v.s1s; d += v.ds; c++;
        end

        inst_valid = 1'b1; inst_opcode = v.op; inst_fn = v.fn;
        inst_num_iter = 16'(v.n); inst_acc = v.acc;
        inst_src0_base = v.s0b; inst_src0_stride = v.s0s;
        inst_src1_base = v.s1b; inst_src1_stride = v.s1s;
        inst_dst_base = v.db; inst_dst_stride = v.ds;
        stall = v.stall_mask[1];

        cyc = 0;
        while (cyc < v.exp_done + 1) begin
            @(posedge clk); #1; cyc++;
            if (cyc == 1) begin
                // Scramble the port so that the DUT must use its latched copy
                inst_opcode = ~v.op; inst_fn = ~v.fn; inst_num_iter = 16'd7;
                inst_acc = ~v.acc; inst_src0_base = 16'h5555; inst_src1_base = 16'h6666;
                inst_dst_base = 16'h7777; inst_src0_stride = 16'd9; inst_dst_stride = 16'd9;
            end

            if (src_rd_en === 1'b1) begin
                if (rd_q.size() == 0) begin
                    check({tag, "_rd_unexpected_cyc"}, cyc, 0);
                end else begin
                    r = rd_q.pop_front();
                    check({tag, "_rd_cyc"}, cyc, r.cyc);
                    check({tag, "_rd_src0"}, src0_rd_addr, r.a0);
                    check({tag, "_rd_src1"}, src1_rd_addr, r.a1);
                end
            end
            if (dst_wr_en === 1'b1) begin
                if (wr_q.size() == 0) begin
                    check({tag, "_wr_unexpected_cyc"}, cyc, 0);
                end else begin
                    w = wr_q.pop_front();
                    check({tag, "_wr_cyc"}, cyc, w.cyc);
                    check({tag, "_wr_addr"}, dst_wr_addr, w.a);
                end
            end

            check({tag, "_busy"}, busy, cyc <= v.exp_done);
            check({tag, "_done"}, done, cyc == v.exp_done);
            check({tag, "_ready"}, inst_ready, cyc > v.exp_done);
            exp_ar = (cyc <= v.exp_done) && (v.acc ? (cyc == 2 && v.n > 0) : 1'b1);
            check({tag, "_acc_reset"}, cu_acc_reset, exp_ar);
            check({tag, "_cu_opcode"}, cu_opcode, (cyc <= v.exp_done) ? v.op : 4'h0);
            check({tag, "_cu_fn"}, cu_fn, (cyc <= v.exp_done) ? v.fn : 4'h0);

            // Offer a bogus instruction while busy. It must be ignored.
            inst_valid = (v.exp_done >= 4) && (cyc == 2 || cyc == 3);
            stall = v.stall_mask[cyc + 1];
        end
        check({tag, "_rd_left"}, rd_q.size(), 0);
        check({tag, "_wr_left"}, wr_q.size(), 0);
        clear_inputs();
    endtask

    initial begin
        int events;

        //             n  acc op    fn    s0b      s0s    s1b      s1s      db       ds       stall  done
        vecs[0] = '{4, 1'b0, 4'h3, 4'h5, 16'h0010, 16'd1, 16'h0040, 16'd2,   16'h0080, 16'd1,   32'h0, 6};
        vecs[1] = '{3, 1'b1, 4'h9, 4'hA, 16'h0100, 16'd1, 16'h0200, 16'd1,   16'h0020, 16'd5,   32'hC, 5};
        vecs[2] = '{0, 1'b0, 4'h6, 4'h2, 16'h0011, 16'd1, 16'h0022, 16'd1,   16'h0033, 16'd1,   32'h0, 1};
        vecs[3] = '{3, 1'b0, 4'h1, 4'h7, 16'h0000, 16'd3, 16'h0500, 16'hFFFF, 16'h0300, 16'd4,   32'h4, 6};
        vecs[4] = '{3, 1'b0, 4'hC, 4'h4, 16'hFFFE, 16'd1, 16'h1234, 16'h0100, 16'hFFFF, 16'd1,   32'h0, 5};
        vecs[5] = '{1, 1'b1, 4'hF, 4'h1, 16'h0007, 16'd0, 16'h0000, 16'd0,   16'h0055, 16'd3,   32'h0, 3};

        clear_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", inst_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", src_rd_en, 0);
        check("rst_wr_en", dst_wr_en, 0);
        check("rst_acc_reset", cu_acc_reset, 0);
        check("rst_cu_opcode", cu_opcode, 0);
        check("rst_src0_addr", src0_rd_addr, 0);
        check("rst_dst_addr", dst_wr_addr, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_ready_after", inst_ready, 1);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of an N=8 instruction
        inst_valid = 1'b1; inst_num_iter = 16'd8; inst_opcode = 4'h2;
        inst_src0_base = 16'h0400; inst_src0_stride = 16'd1;
        inst_dst_base = 16'h0600; inst_dst_stride = 16'd1;
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst_busy_before", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_busy_in_reset", busy, 0);
        check("midrst_wr_in_reset", dst_wr_en, 0);
        events = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (k == 0) check("midrst_ready_after", inst_ready, 1);
            events += int'(src_rd_en) + int'(dst_wr_en) + int'(done) + int'(busy);
        end
        check("midrst_activity", events, 0);

        run_vec(vecs[0], "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
